// File: rtl/insight_e_sink_monitor_pkg.sv
// Package shared by the Insight E sink monitor slice.
// Holds the default widths, the FIFO entry layout and a helper that sizes
// the FIFO read/write pointers.
package insight_e_pkg;

  localparam int DELTA_W_DEFAULT = 16;
  localparam int DEPTH_DEFAULT   = 4;
  localparam int CNT_W_DEFAULT   = 32;

  // One buffered E-channel event: sink flag plus cycles since the previous accept.
  typedef struct packed {
    logic                       sink;
    logic [DELTA_W_DEFAULT-1:0] delta;
  } insight_e_entry_t;

  // Pointers carry one extra wrap bit so full and empty can be told apart
  // when the index bits are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/insight_e_sink_monitor_if.sv
// Handshake bundle for the Insight E sink monitor.
// Upstream E channel : e_valid, e_sink (to monitor), e_ready (from monitor).
// Downstream port    : out_valid, out_sink, out_delta (from monitor), out_ready (to monitor).
// master = the side that produces E beats and consumes the buffered events.
// slave  = the monitor itself.
interface insight_e_sink_monitor_if #(
  parameter int DELTA_W = insight_e_pkg::DELTA_W_DEFAULT
);

  logic               e_valid;
  logic               e_sink;
  logic               e_ready;
  logic               out_valid;
  logic               out_ready;
  logic               out_sink;
  logic [DELTA_W-1:0] out_delta;

  modport master (
    output e_valid,
    output e_sink,
    input  e_ready,
    input  out_valid,
    output out_ready,
    input  out_sink,
    input  out_delta
  );

  modport slave (
    input  e_valid,
    input  e_sink,
    output e_ready,
    output out_valid,
    input  out_ready,
    output out_sink,
    output out_delta
  );

endinterface

// File: rtl/insight_e_sink_monitor_fifo.sv
// insight_e_fifo: generic DEPTH-entry synchronous FIFO, no write-to-read bypass.
// A word pushed into an empty FIFO shows on rdata after the next rising edge.
// Ports:
//   clock, reset  rising-edge clock, asynchronous active-low reset
//   push, wdata   write request and data (ignored while full)
//   pop           read request (ignored while empty)
//   rdata         head word, forced to zero while empty
//   full, empty   occupancy flags from registered pointers
module insight_e_fifo
  import insight_e_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,  // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] WRAP_ONLY = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = ((wr_ptr ^ rd_ptr) == WRAP_ONLY);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately left without reset; the pointers define
  // what is valid, and a resettable array would cost a flop per bit.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // Zeroing the head while empty keeps stale or uninitialised words off the port.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/insight_e_sink_monitor.sv
// insight_e_sink_monitor: receiving end of the hart-0 Insight E channel.
// Accepted beats are tagged with the cycle delta since the previous accept
// and buffered for a downstream valid/ready consumer; accepted, sink-flagged
// and discarded beats are counted for the debug/trace register block.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-low reset
//   enable         1 = buffer beats, 0 = discard mode (beats dropped and counted)
//   clear_counts   one-cycle pulse clearing all three statistics counters
//   bus            E channel in + buffered event out (slave modport)
//   accept_count   accepted beats (wrapping)
//   sink_count     accepted beats with the sink flag set (wrapping)
//   drop_count     beats discarded in discard mode (saturating)
module insight_e_sink_monitor
  import insight_e_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int DELTA_W = DELTA_W_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear_counts,
  insight_e_sink_monitor_if.slave  bus,
  output logic [CNT_W-1:0]         accept_count,
  output logic [CNT_W-1:0]         sink_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int ENTRY_W = 1 + DELTA_W;

  logic               full;
  logic               empty;
  logic               e_ready;
  logic               accept;
  logic               discard;
  logic               pop;
  logic [DELTA_W-1:0] cyc;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // Ready depends only on registered occupancy and enable, never on e_valid.
  // Holding it low while reset is asserted stops a beat being taken against
  // pointers that are being cleared.
  assign e_ready     = reset & (enable ? ~full : 1'b1);
  assign bus.e_ready = e_ready;

  assign accept  = bus.e_valid & e_ready & enable;
  assign discard = bus.e_valid & ~enable;
  assign pop     = ~empty & bus.out_ready;

  assign wr_entry = {bus.e_sink, cyc};

  insight_e_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head_entry),
    .full  (full),
    .empty (empty)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_sink  = head_entry[ENTRY_W-1];
  assign bus.out_delta = head_entry[DELTA_W-1:0];

  // Cycles since the last accept. The captured delta is the pre-edge value,
  // so the counter restarts at 1 and back-to-back accepts report 1. It runs
  // in both modes so toggling enable does not skew the next delta.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc <= '0;
    end else if (accept) begin
      cyc <= DELTA_W'(1);
    end else if (cyc != '1) begin
      cyc <= cyc + DELTA_W'(1);
    end
  end

  // A clear that coincides with a qualifying event leaves the counter at 1,
  // so that event is not lost.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      accept_count <= '0;
      sink_count   <= '0;
      drop_count   <= '0;
    end else if (clear_counts) begin
      accept_count <= accept               ? CNT_W'(1) : '0;
      sink_count   <= (accept & bus.e_sink) ? CNT_W'(1) : '0;
      drop_count   <= discard              ? CNT_W'(1) : '0;
    end else begin
      if (accept)                   accept_count <= accept_count + CNT_W'(1);
      if (accept & bus.e_sink)      sink_count   <= sink_count + CNT_W'(1);
      if (discard && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/insight_e_sink_monitor.md
# insight_e_sink_monitor

Receiving end of the per-hart Insight E channel (valid/ready/sink). It consumes E-channel beats from hart 0 and applies backpressure through `e_ready`. Each accepted beat is buffered with an inter-event cycle delta and presented on a downstream valid/ready port. Accepted, sink-flagged and dropped beats are counted for the debug/trace register block.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DELTA_W`, 16: inter-event delta width; saturating.
- `CNT_W`, 32: statistics counter width.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset; deassertion synchronous to `clock` upstream.
- `enable`  in  1  1 = accept into FIFO; 0 = discard mode.
- `clear_counts`  in  1  single-cycle pulse, zeroes statistics counters.
- `e_valid`  in  1  E-channel beat valid.
- `e_sink`  in  1  E-channel sink flag.
- `e_ready`  out  1  E-channel ready.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream ready.
- `out_sink`  out  1  head entry sink flag.
- `out_delta`  out  DELTA_W  head entry cycle delta.
- `accept_count`  out  CNT_W  accepted beats (wrapping).
- `sink_count`  out  CNT_W  accepted beats with `e_sink`=1 (wrapping).
- `drop_count`  out  CNT_W  beats discarded in discard mode (saturating).

## Operation
- Accept = `e_valid & e_ready & enable`. Discard = `e_valid & ~enable`. Pop = `out_valid & out_ready`.
- `e_ready` = `enable ? ~full : 1`. It is a function of registered state and `enable` only, with no path from `e_valid`.
- In discard mode, beats are dropped and `drop_count` increments, saturating at all-ones. FIFO contents are retained and drain normally.
- Delta counter `cyc` (DELTA_W):
  - On accept, the captured delta is `cyc`, and `cyc` becomes 1.
  - Otherwise `cyc` becomes `cyc+1`, saturating at 2^DELTA_W−1.
  - Back-to-back accepts therefore give delta 1.
- FIFO entry = {sink, delta}. Storage uses read/write pointers of log2(DEPTH)+1 bits.
  - Full: pointers differ only in the MSB.
  - Empty: pointers are equal.
  - Pointers wrap naturally.
- There is no bypass. A beat written into an empty FIFO appears on `out_*` the next cycle.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- When the FIFO is full, `e_ready` is 0, including in a cycle where a pop occurs. It rises the cycle after the pop.
- Counters:
  - Accept increments `accept_count`.
  - Accept with `e_sink`=1 also increments `sink_count`.
  - `clear_counts` zeroes all three counters. If an increment-causing event occurs in the same cycle, that counter becomes 1 instead of 0.
- `enable` toggling does not disturb `cyc`, which keeps running in both modes.

## Timing
- Reset values:
  - `e_ready`=0 while reset is asserted. After reset it follows the rule above, so it is 1 in the first cycle.
  - `out_valid`=0, `out_sink`=0, `out_delta`=0, all counters 0, `cyc`=0, pointers 0.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N, and is popped at the first edge ≥N+1 with `out_ready`=1.
- `out_*` hold stable while `out_valid`=1 and `out_ready`=0.
- Throughput: one beat per cycle sustained when `out_ready`=1.
- Counters update on the edge of the qualifying event and are visible the following cycle.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and FIFO contents are lost.

## Structure
- Package `insight_e_pkg`:
  - `DELTA_W_DEFAULT` constant.
  - `insight_e_entry_t` struct {sink, delta}.
  - Pointer-width helper function.
- Sub-module `insight_e_fifo`: generic DEPTH-entry synchronous FIFO with `full`/`empty` outputs and no bypass, instantiated once.
- The delta counter and statistics counters live in the top module.

## Test plan
- Reset release, `enable`=1, `e_valid` pulsed at cycles 0, 1, 5 → deltas 0, 1, 4. `out_valid` rises cycle 1. `accept_count`=3.
- `out_ready`=0, 6 consecutive `e_valid` → 4 accepted, `e_ready`=0 from cycle 4. `out_ready` raised at cycle 8 → `e_ready`=1 at cycle 9, and order is preserved.
- `enable`=0 with FIFO holding 2 entries, 3 `e_valid` beats → `drop_count`=3, `e_ready`=1, and both entries drain intact.
- `e_valid` idle for 70000 cycles, then one beat with DELTA_W=16 → `out_delta`=65535.
- `clear_counts` coincident with an accept of `e_sink`=1 → `accept_count`=1, `sink_count`=1, `drop_count`=0.
- Reset asserted with 3 entries queued → `out_valid`=0 immediately, and the FIFO is empty after release.
